pwm_duty_decoder: RTL and testbench
===================================

// Module: pwm_duty_decoder
// PURPOSE
//   Receive-side partner of the PWM generator. Samples an asynchronous PWM input,
//   measures high time and period in clk cycles, and reports a quantised duty level.
//   Flags constant-high / constant-low inputs (generator duty 100% / 0%) via timeout.
//   Sits on the loopback/monitor path so the duty setting can be checked in-system.
// PARAMETERS
//   CNT_W       8    width of high/period counters (saturating)
//   EXP_PERIOD  10   expected PWM period in clk cycles; also full-scale duty level
//   LVL_W       4    width of duty_level; must hold EXP_PERIOD
//   TIMEOUT     64   cycles without a rising edge before declaring a stuck input; < 2^CNT_W-1
// PORTS
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-low reset
//   enable      in   1      1 = measure; 0 = return to IDLE, clear counters, hold outputs
//   pwm_in      in   1      PWM input, asynchronous to clk
//   high_cnt    out  CNT_W  high cycles in last complete period
//   period_cnt  out  CNT_W  rising-edge-to-rising-edge cycles of last period
//   duty_level  out  LVL_W  high_cnt when period matches EXP_PERIOD; EXP_PERIOD/0 when stuck
//   valid       out  1      one-cycle pulse when outputs are updated
//   period_err  out  1      last measured period_cnt != EXP_PERIOD
//   stuck_high  out  1      input constant 1 for TIMEOUT cycles
//   stuck_low   out  1      input constant 0 for TIMEOUT cycles
// BEHAVIOUR
//   - Reset (reset=0, async): all outputs 0, state IDLE, counters and sync flops 0.
//   - Input path: 2-flop synchroniser -> s; s_prev registered; rise = s & ~s_prev.
//     Rise detected 3 clk after pwm_in edge; only rises are timing references.
//   - Counters: on rise cyc<=1, hc<=1; else cyc<=cyc+1, hc<=hc+s; both saturate at 2^CNT_W-1.
//   - FSM: IDLE -> ARMED on first rise (no publish; period incomplete).
//     ARMED -> on each rise: publish, stay ARMED.
//     IDLE/ARMED -> STUCK when cyc==TIMEOUT with no rise.
//     STUCK -> ARMED on next rise (no publish; partial period discarded).
//     Any state -> IDLE when enable=0 (outputs hold, counters cleared).
//   - Publish (registered, cycle after rise sampled): period_cnt<=cyc, high_cnt<=hc,
//     period_err<=(cyc!=EXP_PERIOD); duty_level<=hc[LVL_W-1:0] only if cyc==EXP_PERIOD,
//     else duty_level holds; stuck_* <=0; valid=1 for one cycle.
//   - STUCK entry: stuck_high<=s, stuck_low<=~s, duty_level<=s?EXP_PERIOD:0,
//     high_cnt/period_cnt hold, valid pulses once; no further valid while STUCK.
//   - Simultaneous rise and cyc==TIMEOUT: rise wins (publish, no STUCK).
//   - hc never exceeds cyc; high_cnt==period_cnt impossible in ARMED (a rise needs a low).
//   - Reset mid-period: everything cleared; first valid only after two rises.
// TESTING
//   1 Generator period 10, duty 3 -> after 2nd rise: high_cnt=3, period_cnt=10,
//     duty_level=3, period_err=0, valid every 10 cycles.
//   2 Duty steps 5->6 mid-run -> one valid with 5, then first complete period reports 6;
//     no intermediate garbage value.
//   3 pwm_in held 1 for 70 cycles after running -> stuck_high=1, duty_level=10, single
//     valid; release at duty 4 -> stuck_high clears at 2nd rise, duty_level=4.
//   4 pwm_in held 0 from reset -> stuck_low=1 at cycle TIMEOUT(64)+sync, duty_level=0.
//   5 Period 12, high 4 -> period_cnt=12, high_cnt=4, period_err=1, duty_level held.
//   6 reset=0 pulse mid-period, then enable=0 for 5 cycles -> outputs 0 on reset,
//     held during enable=0, first valid two rises after re-enable.

Source files
------------

// File: rtl/pwm_duty_decoder.sv
// Measures the high time and period of an asynchronous PWM input and reports a quantised
// duty level. A missing rising edge for TIMEOUT cycles is flagged as a stuck-high/low input.
module pwm_duty_decoder #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned EXP_PERIOD = 10,
    parameter int unsigned LVL_W      = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [LVL_W-1:0] duty_level,
    output logic             valid,
    output logic             period_err,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam logic [CNT_W-1:0] ExpPeriodCnt = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TimeoutCnt   = CNT_W'(TIMEOUT);
    localparam logic [LVL_W-1:0] FullLevel    = LVL_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] CntMax       = '1;

    typedef enum logic [1:0] {StIdle, StArmed, StStuck} state_e;

    state_e state_q, state_d;

    logic             sync1_q, s_q, s_prev_q;
    logic             rise;
    logic [CNT_W-1:0] cyc_q, hc_q;
    logic             publish, stuck_enter;

    logic [CNT_W-1:0] high_cnt_q, period_cnt_q;
    logic [LVL_W-1:0] duty_level_q;
    logic             valid_q, period_err_q, stuck_high_q, stuck_low_q;

    assign rise = s_q & ~s_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            s_q      <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            sync1_q  <= pwm_in;
            s_q      <= sync1_q;
            s_prev_q <= s_q;
        end
    end

    // The rising-edge cycle itself is high, hence both counters restart at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
            hc_q  <= '0;
        end else if (!enable) begin
            cyc_q <= '0;
            hc_q  <= '0;
        end else if (rise) begin
            cyc_q <= CNT_W'(1);
            hc_q  <= CNT_W'(1);
        end else begin
            if (cyc_q != CntMax) cyc_q <= cyc_q + CNT_W'(1);
            if (hc_q != CntMax)  hc_q  <= hc_q + CNT_W'(s_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // A rise takes priority over the timeout firing in the same cycle.
    always_comb begin
        state_d     = state_q;
        publish     = 1'b0;
        stuck_enter = 1'b0;
        if (!enable) begin
            state_d = StIdle;
        end else if (rise) begin
            publish = (state_q == StArmed);
            state_d = StArmed;
        end else if (state_q != StStuck && cyc_q == TimeoutCnt) begin
            stuck_enter = 1'b1;
            state_d     = StStuck;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            duty_level_q <= '0;
            valid_q      <= 1'b0;
            period_err_q <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            valid_q <= publish | stuck_enter;
            if (publish) begin
                period_cnt_q <= cyc_q;
                high_cnt_q   <= hc_q;
                period_err_q <= (cyc_q != ExpPeriodCnt);
                if (cyc_q == ExpPeriodCnt) duty_level_q <= hc_q[LVL_W-1:0];
                stuck_high_q <= 1'b0;
                stuck_low_q  <= 1'b0;
            end else if (stuck_enter) begin
                stuck_high_q <= s_q;
                stuck_low_q  <= ~s_q;
                duty_level_q <= s_q ? FullLevel : '0;
            end
        end
    end

    assign high_cnt   = high_cnt_q;
    assign period_cnt = period_cnt_q;
    assign duty_level = duty_level_q;
    assign valid      = valid_q;
    assign period_err = period_err_q;
    assign stuck_high = stuck_high_q;
    assign stuck_low  = stuck_low_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: PWM waveforms with hand-computed measurements.
module tb_pwm_duty_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic       pwm_in = 1'b0;
    logic [7:0] high_cnt, period_cnt;
    logic [3:0] duty_level;
    logic       valid, period_err, stuck_high, stuck_low;

    int n_checks = 0;
    int n_fail = 0;
    int cyc_num = 0;
    int vcount = 0;
    int last_v_cyc = 0;
    int prev_v_cyc = 0;
    bit rec = 1'b0;
    logic [7:0] pub_q[$];

    pwm_duty_decoder #(
        .CNT_W(8), .EXP_PERIOD(10), .LVL_W(4), .TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
        .high_cnt(high_cnt), .period_cnt(period_cnt), .duty_level(duty_level),
        .valid(valid), .period_err(period_err),
        .stuck_high(stuck_high), .stuck_low(stuck_low)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_num <= cyc_num + 1;

    always @(negedge clk) begin
        if (valid) begin
            vcount     <= vcount + 1;
            prev_v_cyc <= last_v_cyc;
            last_v_cyc <= cyc_num;
            if (rec) pub_q.push_back(high_cnt);
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_pwm(input int high, input int period, input int n);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < period; c++) begin
                pwm_in = (c < high);
                @(negedge clk);
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int v0;
        int found;

        // Reset state
        idle_cycles(3);
        check_value("rst_high_cnt", 32'(high_cnt), 0);
        check_value("rst_period_cnt", 32'(period_cnt), 0);
        check_value("rst_duty", 32'(duty_level), 0);
        check_value("rst_valid", 32'(valid), 0);
        check_value("rst_flags", 32'({period_err, stuck_high, stuck_low}), 0);
        reset = 1'b1;

        // 1: period 10, duty 3
        v0 = vcount;
        run_pwm(3, 10, 5);
        check_value("t1_high_cnt", 32'(high_cnt), 3);
        check_value("t1_period_cnt", 32'(period_cnt), 10);
        check_value("t1_duty", 32'(duty_level), 3);
        check_value("t1_period_err", 32'(period_err), 0);
        check_value("t1_valid_count", 32'(vcount - v0), 4);
        check_value("t1_valid_spacing", 32'(last_v_cyc - prev_v_cyc), 10);

        // 2: duty 5 for one period, then 6
        rec = 1'b1;
        run_pwm(5, 10, 1);
        run_pwm(6, 10, 3);
        rec = 1'b0;
        check_value("t2_pub_count", 32'(pub_q.size()), 4);
        if (pub_q.size() == 4) begin
            check_value("t2_pub0", 32'(pub_q[0]), 3);
            check_value("t2_pub1", 32'(pub_q[1]), 5);
            check_value("t2_pub2", 32'(pub_q[2]), 6);
            check_value("t2_pub3", 32'(pub_q[3]), 6);
        end
        check_value("t2_duty", 32'(duty_level), 6);

        // 3: held high, then released at duty 4
        v0 = vcount;
        pwm_in = 1'b1;
        idle_cycles(80);
        check_value("t3_stuck_high", 32'(stuck_high), 1);
        check_value("t3_stuck_low", 32'(stuck_low), 0);
        check_value("t3_duty_full", 32'(duty_level), 10);
        check_value("t3_valid_count", 32'(vcount - v0), 2);
        check_value("t3_pc_held", 32'(period_cnt), 10);
        run_pwm(4, 10, 2);
        check_value("t3_still_stuck", 32'(stuck_high), 1);
        run_pwm(4, 10, 2);
        check_value("t3_stuck_cleared", 32'(stuck_high), 0);
        check_value("t3_duty4", 32'(duty_level), 4);
        check_value("t3_high_cnt4", 32'(high_cnt), 4);

        // 5: off-nominal period 12, high 4; duty_level must hold 7
        run_pwm(7, 10, 2);
        check_value("t5_pre_duty7", 32'(duty_level), 7);
        run_pwm(4, 12, 3);
        check_value("t5_period_cnt", 32'(period_cnt), 12);
        check_value("t5_high_cnt", 32'(high_cnt), 4);
        check_value("t5_period_err", 32'(period_err), 1);
        check_value("t5_duty_held", 32'(duty_level), 7);

        // 4: held low from reset
        pwm_in = 1'b0;
        reset = 1'b0;
        idle_cycles(2);
        reset = 1'b1;
        v0 = vcount;
        found = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (stuck_low) begin
                found = i;
                break;
            end
        end
        check_value("t4_stuck_low_time", 32'(found >= 64 && found <= 68), 1);
        idle_cycles(5);
        check_value("t4_stuck_low", 32'(stuck_low), 1);
        check_value("t4_stuck_high", 32'(stuck_high), 0);
        check_value("t4_duty_zero", 32'(duty_level), 0);
        check_value("t4_valid_count", 32'(vcount - v0), 1);

        // 6: reset mid-period, then enable low for 5 cycles
        run_pwm(3, 10, 3);
        check_value("t6_pre_high_cnt", 32'(high_cnt), 3);
        check_value("t6_pre_stuck_low", 32'(stuck_low), 0);
        run_pwm(3, 5, 1);
        reset = 1'b0;
        @(negedge clk);
        check_value("t6_rst_outputs",
                    32'({high_cnt, period_cnt, duty_level, valid, period_err,
                         stuck_high, stuck_low}), 0);
        reset = 1'b1;
        idle_cycles(3);
        v0 = vcount;
        run_pwm(3, 10, 1);
        check_value("t6_rst_first_rise", 32'(vcount - v0), 0);
        run_pwm(3, 10, 1);
        check_value("t6_rst_second_rise", 32'(vcount - v0), 1);
        check_value("t6_rst_high_cnt", 32'(high_cnt), 3);
        v0 = vcount;
        enable = 1'b0;
        run_pwm(2, 5, 1);
        check_value("t6_dis_high_cnt", 32'(high_cnt), 3);
        check_value("t6_dis_period_cnt", 32'(period_cnt), 10);
        check_value("t6_dis_duty", 32'(duty_level), 3);
        check_value("t6_dis_no_valid", 32'(vcount - v0), 0);
        enable = 1'b1;
        run_pwm(5, 10, 1);
        check_value("t6_en_first_rise", 32'(vcount - v0), 0);
        run_pwm(5, 10, 1);
        check_value("t6_en_second_rise", 32'(vcount - v0), 1);
        check_value("t6_en_high_cnt", 32'(high_cnt), 5);
        check_value("t6_en_duty", 32'(duty_level), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
